// File: rtl/bsg_profiler_scanner_pkg.sv
// Shared types for the profiler counter scanner and its epoch timer.
// Trigger sources are encoded one bit per source so they can be OR-reduced.
package bsg_profiler_scanner_pkg;

   typedef enum logic {
      eIdle = 1'b0,
      eScan = 1'b1
   } state_e;

   // Wide enough for any practical configuration; consumers slice as needed.
   localparam int rec_id_w_lp   = 16;
   localparam int rec_data_w_lp = 64;

   typedef struct packed {
      logic                     last;
      logic [rec_id_w_lp-1:0]   id;
      logic [rec_data_w_lp-1:0] data;
   } record_s;

   typedef logic [1:0] trig_src_t;

   localparam trig_src_t trig_none_lp  = 2'b00;
   localparam trig_src_t trig_epoch_lp = 2'b01;
   localparam trig_src_t trig_dump_lp  = 2'b10;

   function automatic logic is_trig(input trig_src_t src);
      return src != trig_none_lp;
   endfunction

endpackage

// File: rtl/bsg_profiler_epoch_timer.sv
// Epoch timer: counts enabled cycles and pulses expiry_o on the last one.
// epoch_cycles_p == 0 removes the timer entirely (manual dumps only).
module bsg_profiler_epoch_timer
   import bsg_profiler_scanner_pkg::*;
#(
   parameter int epoch_cycles_p = 1000
)
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   output logic expiry_o
);

   if (epoch_cycles_p == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk_i, reset_i, en_i};
      assign expiry_o = 1'b0;
   end else begin : g_on
      localparam int tw_lp =
         (epoch_cycles_p > 1) ? $clog2(epoch_cycles_p) : 1;
      localparam logic [tw_lp-1:0] last_lp =
         tw_lp'(epoch_cycles_p - 1);

      logic [tw_lp-1:0] timer_q;
      logic [tw_lp-1:0] timer_d;

      assign expiry_o = en_i & (timer_q == last_lp);

      // Timer freezes while profiling is disabled.
      always_comb begin
         timer_d = timer_q;
         if (expiry_o)
            timer_d = '0;
         else if (en_i)
            timer_d = timer_q + 1'b1;
      end

      always_ff @(posedge clk_i) begin
         if (reset_i)
            timer_q <= '0;
         else
            timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/bsg_profiler_counter_scanner.sv
// Profiling controller: event counters, epoch snapshots, word-serial dump.
// Define BSG_PROFILER_SCANNER_SATURATE_EN to make counters saturate.
module bsg_profiler_counter_scanner
   import bsg_profiler_scanner_pkg::*;
#(
   parameter int els_p          = 32,
   parameter int width_p        = 32,
   parameter int epoch_cycles_p = 1000,
   parameter int lg_els_lp      = (els_p > 1) ? $clog2(els_p) : 1
)
(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 en_i,
   input  logic [els_p-1:0]     countme_i,
   input  logic                 dump_req_i,
   output logic                 v_o,
   output logic [width_p-1:0]   data_o,
   output logic [lg_els_lp-1:0] id_o,
   output logic                 last_o,
   input  logic                 yumi_i,
   output logic                 busy_o,
   output logic                 overrun_o
);

   localparam logic [lg_els_lp-1:0] last_idx_lp =
      lg_els_lp'(els_p - 1);

   logic                 expiry;
   trig_src_t            trig_src;
   logic                 trigger;
   logic                 last_word;
   logic                 handoff;
   logic                 capture;
   logic                 drop;

   state_e               state_q;
   logic [lg_els_lp-1:0] idx_q;
   logic                 overrun_q;

   logic [width_p-1:0]   cnt_q  [els_p];
   logic [width_p-1:0]   cnt_d  [els_p];
   logic [width_p-1:0]   snap_q [els_p];

   bsg_profiler_epoch_timer #(
      .epoch_cycles_p(epoch_cycles_p)
   ) timer (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (en_i),
      .expiry_o(expiry)
   );

   assign trig_src  = {dump_req_i, expiry};
   assign trigger   = is_trig(trig_src);
   assign last_word = (idx_q == last_idx_lp);

   // A trigger landing on the final handshake starts the next scan directly.
   assign handoff = (state_q == eScan) & yumi_i & last_word;
   assign capture = trigger & ((state_q == eIdle) | handoff);
   assign drop    = trigger & (state_q == eScan) & ~handoff;

   function automatic logic [width_p-1:0] bump(
      input logic [width_p-1:0] c
   );
`ifdef BSG_PROFILER_SCANNER_SATURATE_EN
      return (&c) ? c : c + 1'b1;
`else
      return c + 1'b1;
`endif
   endfunction

   // The capture-cycle event is credited to the new epoch.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < els_p; i++) begin
         if (capture) begin
            cnt_d[i]    = '0;
            cnt_d[i][0] = en_i & countme_i[i];
         end else if (en_i & countme_i[i]) begin
            cnt_d[i] = bump(cnt_q[i]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < els_p; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < els_p; i++) begin
            cnt_q[i] <= cnt_d[i];
            if (capture)
               snap_q[i] <= cnt_q[i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= eIdle;
         idx_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (drop)
            overrun_q <= 1'b1;
         unique case (state_q)
            eIdle: begin
               if (capture) begin
                  state_q <= eScan;
                  idx_q   <= '0;
               end
            end
            eScan: begin
               if (capture) begin
                  idx_q <= '0;
               end else if (yumi_i) begin
                  if (last_word) begin
                     state_q <= eIdle;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= eIdle;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign v_o       = (state_q == eScan);
   assign busy_o    = (state_q == eScan);
   assign data_o    = snap_q[idx_q];
   assign id_o      = idx_q;
   assign last_o    = last_word;
   assign overrun_o = overrun_q;

`ifndef SYNTHESIS
   yumi_only_when_valid: assert property (
      @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
   );
`endif

endmodule

// File: tb/tb_bsg_profiler_counter_scanner.sv
// Directed scoreboard bench for bsg_profiler_counter_scanner.
// Main instance: 4 x 8-bit, epoch 10; second instance: 4 x 4-bit, no timer.
module tb_bsg_profiler_counter_scanner;

   localparam int els_lp = 4;
   localparam int w_lp   = 8;
   localparam int ep_lp  = 10;
   localparam int w2_lp  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic            en, dump, yumi;
   logic [3:0]      cm;
   logic            v, last, busy, ovr;
   logic [w_lp-1:0] data;
   logic [1:0]      id;

   logic             en2, dump2, yumi2;
   logic [3:0]       cm2;
   logic             v2, last2, busy2, ovr2;
   logic [w2_lp-1:0] data2;
   logic [1:0]       id2;

   bsg_profiler_counter_scanner #(
      .els_p(els_lp), .width_p(w_lp), .epoch_cycles_p(ep_lp)
   ) dut (
      .clk_i(clk), .reset_i(reset), .en_i(en), .countme_i(cm),
      .dump_req_i(dump), .v_o(v), .data_o(data), .id_o(id),
      .last_o(last), .yumi_i(yumi), .busy_o(busy), .overrun_o(ovr)
   );

   bsg_profiler_counter_scanner #(
      .els_p(els_lp), .width_p(w2_lp), .epoch_cycles_p(0)
   ) dut2 (
      .clk_i(clk), .reset_i(reset), .en_i(en2), .countme_i(cm2),
      .dump_req_i(dump2), .v_o(v2), .data_o(data2), .id_o(id2),
      .last_o(last2), .yumi_i(yumi2), .busy_o(busy2), .overrun_o(ovr2)
   );

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic       last;
   } word_t;

   word_t sb[$];
   int errors = 0;
   int checks = 0;

   logic [7:0] mcnt [4];
   int mtimer;
   bit mscan;
   int midx;
   bit movr;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] bump8(input logic [7:0] c);
`ifdef BSG_PROFILER_SCANNER_SATURATE_EN
      return (c == 8'hff) ? c : c + 8'd1;
`else
      return c + 8'd1;
`endif
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) mcnt[i] = '0;
      mtimer = 0;
      mscan  = 0;
      midx   = 0;
      movr   = 0;
      sb.delete();
   endtask

   // One clock of the main instance: drive, check current word, advance model.
   task automatic tick(input bit wy, input bit dr);
      bit    y, ex, trig, hand, cap, hit;
      word_t w;
      y    = wy & mscan;
      yumi = y;
      dump = dr;
      if (mscan) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed v_o=%0b expected queued word", v);
         end else begin
            w = sb[0];
            chk("id_o", id, w.id);
            chk("data_o", data, w.data);
            chk("last_o", last, w.last);
            if (y) void'(sb.pop_front());
         end
      end
      ex   = en && (mtimer == ep_lp - 1);
      trig = ex | dr;
      hand = y && (midx == 3);
      cap  = trig && (!mscan || hand);
      if (trig && mscan && !hand) movr = 1;
      if (cap)
         for (int i = 0; i < 4; i++)
            sb.push_back('{id: 2'(i), data: mcnt[i], last: (i == 3)});
      for (int i = 0; i < 4; i++) begin
         hit = en & cm[i];
         if (cap) mcnt[i] = {7'd0, hit};
         else if (hit) mcnt[i] = bump8(mcnt[i]);
      end
      if (cap) begin
         mscan = 1;
         midx  = 0;
      end else if (y) begin
         if (midx == 3) begin
            mscan = 0;
            midx  = 0;
         end else begin
            midx++;
         end
      end
      if (ex) mtimer = 0;
      else if (en) mtimer++;
      @(posedge clk);
      #1;
      chk("v_o", v, mscan);
      chk("busy_o", busy, mscan);
      chk("overrun_o", ovr, movr);
      yumi = 0;
      dump = 0;
   endtask

   task automatic wait_scan(input int max);
      int n = 0;
      while (!mscan && n < max) begin
         tick(0, 0);
         n++;
      end
      checks++;
      assert (mscan) else begin
         errors++;
         $error("FAIL wait_scan: observed no trigger expected one in %0d", max);
      end
   endtask

   task automatic drain(input int max);
      int n = 0;
      while (mscan && n < max) begin
         tick(1, 0);
         n++;
      end
   endtask

   initial begin
      word_t w;
      logic [7:0] exp5;
      reset = 1; en = 0; dump = 0; yumi = 0; cm = '0;
      en2 = 0; dump2 = 0; yumi2 = 0; cm2 = '0;
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 0;
      chk("rst v_o", v, 0);
      chk("rst busy_o", busy, 0);
      chk("rst overrun_o", ovr, 0);
      chk("rst id_o", id, 0);
      chk("rst data_o", data, 0);

      // Epoch expiry with a consumer that always accepts.
      en = 1;
      cm = 4'b0101;
      repeat (14) tick(1, 0);

      // Stalled consumer, then a manual dump dropped mid-scan.
      wait_scan(20);
      repeat (5) tick(0, 0);
      tick(1, 0);
      tick(0, 1);
      chk("overrun set", ovr, 1);
      drain(10);

      // Dump coincident with the final handshake starts a new scan.
      wait_scan(20);
      tick(1, 0);
      tick(1, 0);
      tick(1, 0);
      tick(1, 1);
      chk("handoff id_o", id, 0);
      drain(10);

      // Profiling disabled: no expiry and no counting.
      en = 0;
      cm = 4'hf;
      repeat (50) tick(0, 0);
      tick(0, 1);
      tick(1, 0);

      // Reset mid-scan aborts the stream and clears overrun.
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      model_clear();
      chk("midrst v_o", v, 0);
      chk("midrst overrun_o", ovr, 0);
      repeat (3) tick(0, 0);

      // Narrow counters: 20 events into 4 bits.
`ifdef BSG_PROFILER_SCANNER_SATURATE_EN
      exp5 = 8'd15;
`else
      exp5 = 8'd4;
`endif
      en2 = 1;
      cm2 = 4'b0001;
      repeat (20) @(posedge clk);
      #1;
      en2 = 0;
      dump2 = 1;
      for (int i = 0; i < 4; i++)
         sb.push_back('{id: 2'(i), data: (i == 0) ? exp5 : 8'd0,
                        last: (i == 3)});
      @(posedge clk);
      #1;
      dump2 = 0;
      for (int k = 0; k < 4; k++) begin
         w = sb.pop_front();
         chk("w2 v_o", v2, 1);
         chk("w2 id_o", id2, w.id);
         chk("w2 data_o", data2, w.data[3:0]);
         chk("w2 last_o", last2, w.last);
         yumi2 = 1;
         @(posedge clk);
         #1;
         yumi2 = 0;
      end
      chk("w2 done v_o", v2, 0);
      chk("w2 overrun_o", ovr2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
